// File: rtl/usb_utm_tx.sv
// USB 2.0 full-speed transmit serializer: SYNC, bit stuffing, NRZI and EOP
// generation behind a UTMI-style TxValid/TxReady byte handshake.
module usb_utm_tx #(
    parameter int CLK_PER_BIT  = 4,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic       clk_48m,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       dp_tx,
    output logic       dn_tx,
    output logic       tx_oe
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int EOP_W = $clog2(EOP_SE0_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] READY_CNT = CNT_W'(CLK_PER_BIT - 2);
    localparam logic [EOP_W-1:0] EOP_LAST  = EOP_W'(EOP_SE0_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [EOP_W-1:0] r_eop_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_byte;
    logic [2:0]       r_ones;
    logic             r_stuff;
    logic             r_dp;
    logic             r_dn;
    logic             r_oe;
    logic             r_active;
    logic             r_ready;

    logic       w_period_end;
    logic       w_ready_slot;
    logic       w_stuff_next;
    logic       w_byte_end;
    logic [2:0] w_next_idx;
    logic       w_send_bit;

    assign w_period_end = (r_bit_cnt == LAST_CNT);
    assign w_ready_slot = (r_bit_cnt == READY_CNT);
    assign w_stuff_next = !r_stuff && (r_ones == 3'd6);
    // A byte ends after bit 7, or after the stuff bit that bit 7 triggered.
    assign w_byte_end   = (r_bit_idx == 3'd7) && !w_stuff_next;
    assign w_next_idx   = r_bit_idx + 3'd1;
    assign w_send_bit   = w_byte_end ? tx_data[0] : r_byte[w_next_idx];

    always_ff @(posedge clk_48m or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_eop_cnt <= '0;
            r_bit_idx <= 3'd0;
            r_byte    <= 8'h00;
            r_ones    <= 3'd0;
            r_stuff   <= 1'b0;
            r_dp      <= 1'b1;
            r_dn      <= 1'b0;
            r_oe      <= 1'b0;
            r_active  <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= '0;
                    r_dp      <= 1'b1;
                    r_dn      <= 1'b0;
                    r_oe      <= 1'b0;
                    r_active  <= 1'b0;
                    if (tx_valid) begin
                        // SYNC bit 0 is a raw 0, so the line leaves J for K at once.
                        r_state   <= S_SYNC;
                        r_oe      <= 1'b1;
                        r_active  <= 1'b1;
                        r_dp      <= 1'b0;
                        r_dn      <= 1'b1;
                        r_byte    <= 8'h80;
                        r_bit_idx <= 3'd0;
                        r_ones    <= 3'd0;
                        r_stuff   <= 1'b0;
                    end
                end
                S_SYNC, S_DATA: begin
                    r_bit_cnt <= w_period_end ? '0 : r_bit_cnt + 1'b1;
                    if (w_ready_slot && w_byte_end) begin
                        r_ready <= 1'b1;
                    end
                    if (w_period_end) begin
                        r_stuff <= 1'b0;
                        if (w_stuff_next) begin
                            r_dp    <= ~r_dp;
                            r_dn    <= ~r_dn;
                            r_ones  <= 3'd0;
                            r_stuff <= 1'b1;
                        end else if (w_byte_end && !tx_valid) begin
                            r_state   <= S_EOP_SE0;
                            r_dp      <= 1'b0;
                            r_dn      <= 1'b0;
                            r_eop_cnt <= '0;
                        end else begin
                            if (w_byte_end) begin
                                r_state   <= S_DATA;
                                r_byte    <= tx_data;
                                r_bit_idx <= 3'd0;
                            end else begin
                                r_bit_idx <= w_next_idx;
                            end
                            if (w_send_bit) begin
                                r_ones <= r_ones + 3'd1;
                            end else begin
                                r_dp   <= ~r_dp;
                                r_dn   <= ~r_dn;
                                r_ones <= 3'd0;
                            end
                        end
                    end
                end
                S_EOP_SE0: begin
                    r_bit_cnt <= w_period_end ? '0 : r_bit_cnt + 1'b1;
                    if (w_period_end) begin
                        if (r_eop_cnt == EOP_LAST) begin
                            r_state <= S_EOP_J;
                            r_dp    <= 1'b1;
                            r_dn    <= 1'b0;
                        end else begin
                            r_eop_cnt <= r_eop_cnt + 1'b1;
                        end
                    end
                end
                S_EOP_J: begin
                    r_bit_cnt <= w_period_end ? '0 : r_bit_cnt + 1'b1;
                    if (w_period_end) begin
                        r_state  <= S_IDLE;
                        r_oe     <= 1'b0;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready  = r_ready;
    assign tx_active = r_active;
    assign dp_tx     = r_dp;
    assign dn_tx     = r_dn;
    assign tx_oe     = r_oe;

endmodule

// File: tb/tb_usb_utm_tx.sv
// Bench for usb_utm_tx: a packet-level encoder model fills per-clock stimulus
// and expected-line queues, which are replayed and compared clock by clock.
module tb_usb_utm_tx;

    localparam int CPB  = 4;
    localparam int SE0B = 2;

    logic       clk_48m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready;
    logic       tx_active;
    logic       dp_tx;
    logic       dn_tx;
    logic       tx_oe;

    usb_utm_tx #(
        .CLK_PER_BIT  (CPB),
        .EOP_SE0_BITS (SE0B)
    ) dut (
        .clk_48m   (clk_48m),
        .rst_n     (rst_n),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx_active (tx_active),
        .dp_tx     (dp_tx),
        .dn_tx     (dn_tx),
        .tx_oe     (tx_oe)
    );

    always #10 clk_48m = ~clk_48m;

    int n_cmp = 0;
    int n_err = 0;

    // Per-clock scoreboard: {tx_valid, tx_data} in, {oe, active, dp, dn, ready} out.
    logic [8:0] stim_q[$];
    logic [4:0] exp_q[$];
    int         id_q[$];

    int exp_oe[16];
    int exp_rdy[16];
    int obs_oe[16];
    int obs_rdy[16];
    int n_pkt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_idle(input int k);
        for (int i = 0; i < k; i++) begin
            stim_q.push_back({1'b0, 8'($urandom)});
            exp_q.push_back(5'b00100);
            id_q.push_back(-1);
        end
    endtask

    // mode 0: tx_valid steady; 1: tx_valid toggles randomly between fetches;
    // 2: tx_valid held high through EOP (next packet must follow with no gap).
    task automatic gen_packet(input int n, input logic [7:0] b0, input logic [7:0] b1, input int mode);
        logic [7:0] rb[3];
        logic [1:0] sym[$];
        bit         mark[$];
        logic [1:0] ln;
        logic       v;
        logic       rdy;
        logic [7:0] d;
        int         ones;
        int         fi;
        int         eop_start;
        int         id;
        id = n_pkt;
        n_pkt++;
        rb[0] = 8'h80;
        rb[1] = b0;
        rb[2] = b1;
        ln = 2'b10;
        ones = 0;
        for (int k = 0; k <= n; k++) begin
            for (int i = 0; i < 8; i++) begin
                if (rb[k][i] == 1'b0) begin
                    ln = ~ln;
                    ones = 0;
                end else begin
                    ones++;
                end
                sym.push_back(ln);
                mark.push_back(1'b0);
                if (ones == 6) begin
                    ln = ~ln;
                    ones = 0;
                    sym.push_back(ln);
                    mark.push_back(1'b0);
                end
            end
            mark[mark.size()-1] = 1'b1;
        end
        eop_start = sym.size();
        for (int i = 0; i < SE0B; i++) begin
            sym.push_back(2'b00);
            mark.push_back(1'b0);
        end
        sym.push_back(2'b10);
        mark.push_back(1'b0);
        exp_oe[id]  = sym.size() * CPB;
        exp_rdy[id] = n + 1;
        obs_oe[id]  = 0;
        obs_rdy[id] = 0;

        stim_q.push_back({1'b1, 8'($urandom)});
        exp_q.push_back(5'b00100);
        id_q.push_back(id);
        fi = 0;
        for (int s = 0; s < sym.size(); s++) begin
            for (int c = 0; c < CPB; c++) begin
                rdy = mark[s] && (c == CPB - 1);
                d = 8'($urandom);
                if (rdy) begin
                    if (fi < n) begin
                        v = 1'b1;
                        d = rb[fi+1];
                    end else begin
                        v = 1'b0;
                    end
                    fi++;
                end else if (s >= eop_start) begin
                    v = (mode == 2);
                end else if (mode == 1) begin
                    v = 1'($urandom_range(0, 1));
                end else begin
                    v = 1'b1;
                end
                stim_q.push_back({v, d});
                exp_q.push_back({2'b11, sym[s], rdy});
                id_q.push_back(id);
            end
        end
    endtask

    task automatic run_queue();
        logic [8:0] st;
        logic [4:0] e;
        int         id;
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            tx_valid = st[8];
            tx_data  = st[7:0];
            @(negedge clk_48m);
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            check_val("line{oe,act,dp,dn,rdy}", {27'd0, tx_oe, tx_active, dp_tx, dn_tx, tx_ready}, {27'd0, e});
            if (id >= 0) begin
                if (tx_oe) obs_oe[id]++;
                if (tx_ready) obs_rdy[id]++;
            end
            @(posedge clk_48m);
            #1;
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        int base;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk_48m);
        @(negedge clk_48m);
        check_val("reset_state", {27'd0, tx_oe, tx_active, dp_tx, dn_tx, tx_ready}, 32'h04);
        rst_n = 1'b1;
        @(posedge clk_48m);
        #1;

        push_idle(3);
        gen_packet(1, 8'h00, 8'h00, 0);
        push_idle(3);
        gen_packet(1, 8'hFF, 8'h00, 0);
        push_idle(2);
        gen_packet(2, 8'hFF, 8'hFF, 0);
        push_idle(2);
        gen_packet(1, 8'hFC, 8'h00, 0);
        push_idle(1);
        gen_packet(2, 8'h5A, 8'hC3, 1);
        push_idle(2);
        gen_packet(1, 8'h3C, 8'h00, 2);
        gen_packet(1, 8'h81, 8'h00, 0);
        push_idle(2);
        gen_packet(2, 8'hFE, 8'h01, 0);
        push_idle(2);
        run_queue();

        check_val("oe_len_0x00", obs_oe[0], 76);
        check_val("oe_len_0xFF", obs_oe[1], 80);

        // Abort mid-DATA with an asynchronous reset.
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        repeat (45) @(posedge clk_48m);
        #3;
        check_val("pre_reset_oe", {31'd0, tx_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_oe", {31'd0, tx_oe}, 32'd0);
        check_val("rst_dp", {31'd0, dp_tx}, 32'd1);
        check_val("rst_dn", {31'd0, dn_tx}, 32'd0);
        check_val("rst_ready", {31'd0, tx_ready}, 32'd0);
        check_val("rst_active", {31'd0, tx_active}, 32'd0);
        repeat (2) @(posedge clk_48m);
        #1;
        check_val("rst_hold", {27'd0, tx_oe, tx_active, dp_tx, dn_tx, tx_ready}, 32'h04);
        tx_valid = 1'b0;
        @(negedge clk_48m);
        rst_n = 1'b1;
        @(posedge clk_48m);
        #1;

        base = n_pkt;
        gen_packet(1, 8'h00, 8'h00, 0);
        push_idle(2);
        run_queue();
        check_val("post_rst_oe_len", obs_oe[base], 76);
        check_val("post_rst_rdy_cnt", obs_rdy[base], 2);

        for (int p = 0; p < n_pkt; p++) begin
            $display("pkt %0d: tx_oe %0d clocks (model %0d), tx_ready %0d pulses (model %0d)",
                     p, obs_oe[p], exp_oe[p], obs_rdy[p], exp_rdy[p]);
            check_val("oe_len", obs_oe[p], exp_oe[p]);
            check_val("ready_cnt", obs_rdy[p], exp_rdy[p]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
